// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: stall requests and exception inputs in, stall/flush/redirect outputs out.
interface pipe_ctrl_if;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        timeout_o;
  logic [31:0] stall_cnt;
  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, cp0_epc_i,
    input  stall, flush, new_pc, timeout_o, stall_cnt
  );
  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, cp0_epc_i,
    output stall, flush, new_pc, timeout_o, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall merge, exception flush, mem-wait watchdog and stall-cycle counter.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter int          TIMEOUT    = 16
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN, MEMWAIT, FLUSH} state_t;
  state_t      state, state_nx;
  logic [15:0] cnt, cnt_nx;
  logic [31:0] stall_cnt;
  logic [5:0]  stall_v, prio;
  logic [31:0] new_pc_v;
  logic        flush_v, tmo, exc;
  assign prio = bus.stallreq_mem ? 6'b011111 :
                bus.stallreq_ex  ? 6'b001111 :
                bus.stallreq_id  ? 6'b000111 :
                bus.stallreq_if  ? 6'b000011 : 6'b000000;
  assign exc = (bus.excepttype_i != '0) && (state != FLUSH);
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    stall_v  = '0;
    flush_v  = 1'b0;
    new_pc_v = '0;
    tmo      = 1'b0;
    if (state == FLUSH) begin
      flush_v  = 1'b1;
      new_pc_v = EXC_VECTOR;
      state_nx = RUN;
      cnt_nx   = '0;
    end else if (exc) begin
      flush_v  = 1'b1;
      new_pc_v = (bus.excepttype_i == 32'h0000_000e) ? bus.cp0_epc_i : EXC_VECTOR;
      state_nx = RUN;
      cnt_nx   = '0;
    end else begin
      stall_v = prio;
      if (state == RUN) begin
        state_nx = bus.stallreq_mem ? MEMWAIT : RUN;
        cnt_nx   = bus.stallreq_mem ? 16'd1 : '0;
      end else if (!bus.stallreq_mem) begin
        state_nx = RUN;
        cnt_nx   = '0;
      end else if (cnt == 16'(TIMEOUT - 1)) begin
        state_nx = FLUSH;
        cnt_nx   = '0;
        tmo      = 1'b1;
      end else begin
        cnt_nx   = cnt + 16'd1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      cnt       <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      stall_cnt <= stall_cnt + {31'd0, stall_v[0]};
    end
  end
  // Outputs are forced to their reset values while reset is held, regardless of requests.
  assign bus.stall     = rst ? stall_v  : '0;
  assign bus.flush     = rst & flush_v;
  assign bus.new_pc    = rst ? new_pc_v : '0;
  assign bus.timeout_o = rst & tmo;
  assign bus.stall_cnt = stall_cnt;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: table-driven vectors plus hand-written watchdog and reset sequences.
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  pipe_ctrl_if bus();
  pipe_ctrl #(.EXC_VECTOR(32'h0000_0020), .TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    string       nm;
    logic        r;
    logic [3:0]  req;
    logic [31:0] exc;
    logic [31:0] epc;
    logic [5:0]  es;
    logic        ef;
    logic [31:0] ep;
    logic        et;
    logic [31:0] ec;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(string nm, logic r, logic [3:0] req, logic [31:0] exc, logic [31:0] epc,
                              logic [5:0] es, logic ef, logic [31:0] ep, logic et, logic [31:0] ec);
    vec_t v;
    v.nm = nm; v.r = r; v.req = req; v.exc = exc; v.epc = epc;
    v.es = es; v.ef = ef; v.ep = ep; v.et = et; v.ec = ec;
    return v;
  endfunction
  task automatic check(string nm, logic [5:0] es, logic ef, logic [31:0] ep, logic et, logic [31:0] ec);
    n_vec++;
    if (bus.stall !== es || bus.flush !== ef || bus.new_pc !== ep || bus.timeout_o !== et || bus.stall_cnt !== ec) begin
      n_bad++;
      $display("FAIL %s: got stall=%b flush=%b new_pc=%h timeout=%b stall_cnt=%0d, want stall=%b flush=%b new_pc=%h timeout=%b stall_cnt=%0d",
               nm, bus.stall, bus.flush, bus.new_pc, bus.timeout_o, bus.stall_cnt, es, ef, ep, et, ec);
    end
  endtask
  task automatic step(vec_t v);
    @(negedge clk);
    rst              = v.r;
    bus.stallreq_mem = v.req[3];
    bus.stallreq_ex  = v.req[2];
    bus.stallreq_id  = v.req[1];
    bus.stallreq_if  = v.req[0];
    bus.excepttype_i = v.exc;
    bus.cp0_epc_i    = v.epc;
    #2;
    check(v.nm, v.es, v.ef, v.ep, v.et, v.ec);
  endtask
  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, want finish before 100000");
    $fatal(1, "global timeout");
  end
  initial begin
    bus.stallreq_if = 1'b0; bus.stallreq_id = 1'b0; bus.stallreq_ex = 1'b0; bus.stallreq_mem = 1'b0;
    bus.excepttype_i = '0; bus.cp0_epc_i = '0;
    tbl.push_back(mk("reset",      1'b0, 4'b0000, 32'h0, 32'h0,    6'b000000, 1'b0, 32'h0,    1'b0, 0));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk("idle",     1'b1, 4'b0000, 32'h0, 32'h0,    6'b000000, 1'b0, 32'h0,    1'b0, 0));
    tbl.push_back(mk("id_ex_a",    1'b1, 4'b0110, 32'h0, 32'h0,    6'b001111, 1'b0, 32'h0,    1'b0, 0));
    tbl.push_back(mk("id_ex_b",    1'b1, 4'b0110, 32'h0, 32'h0,    6'b001111, 1'b0, 32'h0,    1'b0, 1));
    tbl.push_back(mk("id_a",       1'b1, 4'b0010, 32'h0, 32'h0,    6'b000111, 1'b0, 32'h0,    1'b0, 2));
    tbl.push_back(mk("id_b",       1'b1, 4'b0010, 32'h0, 32'h0,    6'b000111, 1'b0, 32'h0,    1'b0, 3));
    tbl.push_back(mk("drop_all",   1'b1, 4'b0000, 32'h0, 32'h0,    6'b000000, 1'b0, 32'h0,    1'b0, 4));
    tbl.push_back(mk("if_only",    1'b1, 4'b0001, 32'h0, 32'h0,    6'b000011, 1'b0, 32'h0,    1'b0, 4));
    tbl.push_back(mk("all_req",    1'b1, 4'b1111, 32'h0, 32'h0,    6'b011111, 1'b0, 32'h0,    1'b0, 5));
    tbl.push_back(mk("mw_release", 1'b1, 4'b0000, 32'h0, 32'h0,    6'b000000, 1'b0, 32'h0,    1'b0, 6));
    tbl.push_back(mk("mem_1",      1'b1, 4'b1000, 32'h0, 32'h0,    6'b011111, 1'b0, 32'h0,    1'b0, 6));
    tbl.push_back(mk("mem_2",      1'b1, 4'b1000, 32'h0, 32'h0,    6'b011111, 1'b0, 32'h0,    1'b0, 7));
    tbl.push_back(mk("mem_3",      1'b1, 4'b1000, 32'h0, 32'h0,    6'b011111, 1'b0, 32'h0,    1'b0, 8));
    tbl.push_back(mk("syscall",    1'b1, 4'b1000, 32'h8, 32'h0,    6'b000000, 1'b1, 32'h20,   1'b0, 9));
    tbl.push_back(mk("post_sys",   1'b1, 4'b1000, 32'h0, 32'h0,    6'b011111, 1'b0, 32'h0,    1'b0, 9));
    tbl.push_back(mk("idle_2",     1'b1, 4'b0000, 32'h0, 32'h0,    6'b000000, 1'b0, 32'h0,    1'b0, 10));
    tbl.push_back(mk("eret",       1'b1, 4'b0000, 32'he, 32'h1234, 6'b000000, 1'b1, 32'h1234, 1'b0, 10));
    tbl.push_back(mk("post_eret",  1'b1, 4'b0000, 32'h0, 32'h1234, 6'b000000, 1'b0, 32'h0,    1'b0, 10));
    tbl.push_back(mk("exc_vs_req", 1'b1, 4'b0110, 32'h4, 32'h1234, 6'b000000, 1'b1, 32'h20,   1'b0, 10));
    tbl.push_back(mk("idle_3",     1'b1, 4'b0000, 32'h0, 32'h0,    6'b000000, 1'b0, 32'h0,    1'b0, 10));
    foreach (tbl[i]) step(tbl[i]);
    // Watchdog: mem stall held from cycle 0; exception in the FLUSH cycle is ignored.
    for (int k = 0; k < 16; k++)
      step(mk("wd_stall", 1'b1, 4'b1000, 32'h0, 32'h0, 6'b011111, 1'b0, 32'h0, k == 15, 10 + k));
    step(mk("wd_flush",   1'b1, 4'b1000, 32'h8, 32'h1234, 6'b000000, 1'b1, 32'h20, 1'b0, 26));
    step(mk("wd_restall", 1'b1, 4'b1000, 32'h0, 32'h0,    6'b011111, 1'b0, 32'h0,  1'b0, 26));
    step(mk("wd_release", 1'b1, 4'b0000, 32'h0, 32'h0,    6'b000000, 1'b0, 32'h0,  1'b0, 27));
    // Exception arriving exactly on the would-be timeout cycle wins.
    for (int k = 0; k < 15; k++)
      step(mk("ov_stall", 1'b1, 4'b1000, 32'h0, 32'h0, 6'b011111, 1'b0, 32'h0, 1'b0, 27 + k));
    step(mk("ov_exc",  1'b1, 4'b1000, 32'h8, 32'h0, 6'b000000, 1'b1, 32'h20, 1'b0, 42));
    step(mk("ov_idle", 1'b1, 4'b0000, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h0,  1'b0, 42));
    // Async reset while in MEMWAIT, then a fresh full watchdog interval.
    for (int k = 0; k < 5; k++)
      step(mk("rs_stall", 1'b1, 4'b1000, 32'h0, 32'h0, 6'b011111, 1'b0, 32'h0, 1'b0, 42 + k));
    rst = 1'b0;
    #1;
    check("rs_async", 6'b000000, 1'b0, 32'h0, 1'b0, 0);
    for (int k = 0; k < 16; k++)
      step(mk("rs_fresh", 1'b1, 4'b1000, 32'h0, 32'h0, 6'b011111, 1'b0, 32'h0, k == 15, k));
    step(mk("rs_flush", 1'b1, 4'b1000, 32'h0, 32'h0, 6'b000000, 1'b1, 32'h20, 1'b0, 16));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline controller for the 6-stage integer core (pc, if, id, ex, mem, wb).
- Merges per-stage stall requests into the stall[5:0] vector consumed by every pipeline register.
- Raises flush and new_pc on exceptions signalled by the mem stage.
- Runs a memory-wait watchdog that converts a hung mem-stage stall into a forced flush to the exception vector.
- Keeps a free-running stall-cycle counter for performance monitoring.

Parameters:
EXC_VECTOR, 32'h0000_0020, exception entry address driven on new_pc for all non-eret exceptions and for watchdog timeout.
TIMEOUT, 16, maximum consecutive cycles stallreq_mem may be held before the watchdog fires (legal range 2..65535).

Ports:
clk  in  1  core clock, all state on rising edge.
rst  in  1  asynchronous, active-low reset.
stallreq_if  in  1  fetch stage requests stall.
stallreq_id  in  1  decode stage requests stall (load-use).
stallreq_ex  in  1  execute stage requests stall (multi-cycle mul/div).
stallreq_mem  in  1  mem stage requests stall (data bus wait).
excepttype_i  in  32  exception code from mem stage; 0 = none.
cp0_epc_i  in  32  current EPC from CP0, used for eret.
stall  out  6  stall vector; bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb.
flush  out  1  kill all pipeline registers this cycle.
new_pc  out  32  redirect target, valid only while flush=1.
timeout_o  out  1  one-cycle pulse when the watchdog fires.
stall_cnt  out  32  count of cycles with stall[0]=1.

Behaviour:
- Reset (rst=0, async): state=RUN, wait counter=0, stall=6'b000000, flush=0, new_pc=0, timeout_o=0, stall_cnt=0.
- FSM states: RUN, MEMWAIT, FLUSH.
- Stall priority, highest first; applies in RUN and MEMWAIT when no flush is active:
  - stallreq_mem -> 6'b011111
  - stallreq_ex -> 6'b001111
  - stallreq_id -> 6'b000111
  - stallreq_if -> 6'b000011
  - none -> 6'b000000
- Exception flush:
  - In RUN or MEMWAIT, excepttype_i!=0 gives flush=1 and stall=0 in the same cycle (combinational).
  - new_pc = cp0_epc_i if excepttype_i==32'h0000_000e (eret), else EXC_VECTOR.
  - Next state = RUN and the wait counter clears.
  - An exception outranks every stall request and the watchdog.
- RUN:
  - stallreq_mem=1 with no exception -> MEMWAIT; wait counter loads 1.
- MEMWAIT:
  - stallreq_mem=0 -> RUN; counter clears.
  - stallreq_mem=1 and counter==TIMEOUT-1 -> FLUSH; timeout_o=1 in that cycle.
  - Otherwise the counter increments.
- FLUSH: lasts exactly one cycle.
  - Outputs: flush=1, stall=0, new_pc=EXC_VECTOR; all stall requests are ignored.
  - An exception arriving in this cycle is ignored; the flush discards its instruction.
  - Next state = RUN.
- new_pc is 0 whenever flush=0.
- flush is registered-state-driven in FLUSH and combinational from excepttype_i otherwise.
- stall is a pure function of state and the current inputs (combinational).
- stall_cnt:
  - Increments by 1 on each rising edge where stall[0]=1.
  - Wraps from 32'hFFFF_FFFF to 0.
  - Holds during flush cycles because stall=0 then.
- Mid-operation reset: async return to reset values from any state; no pulse is generated.
- Watchdog latency: with stallreq_mem held continuously from cycle 0, flush is asserted in cycle TIMEOUT (the FLUSH state).
  - timeout_o pulses in cycle TIMEOUT-1.
  - Total mem stall cycles = TIMEOUT.

Test Plan:
- Reset then idle: all requests 0, excepttype_i=0 for 10 cycles -> stall=0, flush=0, stall_cnt=0.
- Priority merge: stallreq_id=1 and stallreq_ex=1 together -> stall=6'b001111. Drop ex only -> 6'b000111. Drop all -> stall_cnt = number of stalled cycles.
- Syscall during mem stall: stallreq_mem=1 for 3 cycles, then excepttype_i=32'h8 -> flush=1, stall=0, new_pc=32'h20 that cycle. Next cycle state=RUN, counter cleared.
- eret: cp0_epc_i=32'h0000_1234, excepttype_i=32'he -> flush=1, new_pc=32'h1234 for one cycle.
- Watchdog, TIMEOUT=16: hold stallreq_mem=1 indefinitely.
  - Cycles 0..15: stall=6'b011111.
  - Cycle 15: timeout_o=1.
  - Cycle 16: flush=1, new_pc=32'h20, stall=0.
  - Cycle 17: stall=6'b011111 again.
- Async reset in MEMWAIT: assert rst=0 mid-cycle -> outputs return to reset values immediately. After release, no timeout occurs until TIMEOUT fresh stall cycles have passed.
